cache_mem_arbiter: RTL
======================

# cache_mem_arbiter

Sequences and shares the single SRAM-like memory port between the instruction cache refill path and the data cache / uncached data path. It grants one requester at a time with round-robin priority and drives a registered address/data handshake on the memory side. It returns read data with a one-cycle `*_dok` pulse on the granted side. It sits between `instr_cache` / the data cache and the AXI bridge.

## Interface
- `RR_INIT`, default 0: requester that wins the first simultaneous request after reset (0 = data, 1 = instruction).
- `clk`  in  1  single clock; all state changes on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `inst_cache_req`  in  1  instruction read request; held until `inst_cache_dok` or withdrawn.
- `inst_cache_addr`  in  32  instruction read address, word aligned.
- `inst_cache_rdata`  out  32  read data, valid while `inst_cache_dok`=1.
- `inst_cache_dok`  out  1  one-cycle completion pulse.
- `data_cache_req`  in  1  data request; held until `data_cache_dok` or withdrawn.
- `data_cache_wr`  in  1  1 = write, 0 = read.
- `data_cache_addr`  in  32  data address.
- `data_cache_wdata`  in  32  write data.
- `data_cache_wstrb`  in  4  byte enables for writes (ignored for reads).
- `data_cache_rdata`  out  32  read data, valid while `data_cache_dok`=1.
- `data_cache_dok`  out  1  one-cycle completion pulse (reads and writes).
- `mem_req`  out  1  memory request; held until `mem_addr_ok`.
- `mem_wr`, `mem_addr[31:0]`, `mem_wdata[31:0]`, `mem_wstrb[3:0]`  out  request payload, stable while `mem_req`=1.
- `mem_addr_ok`  in  1  request accepted this cycle when `mem_req`=1.
- `mem_data_ok`  in  1  response for the outstanding request this cycle.
- `mem_rdata`  in  32  read data, valid with `mem_data_ok`.

## Operation
- States: IDLE, ADDR, WAIT, RESP. At most one outstanding memory transaction.
- IDLE: if any request is high, grant it; if both are high, grant the side not served last (`last` register, reset to select `RR_INIT` first). At grant, latch `owner`, `wr`, `addr`, `wdata`, `wstrb` (writes: `wstrb` as given; reads: 0) and go to ADDR.
- ADDR: `mem_req`=1 with latched payload. On `mem_addr_ok`, go to WAIT. If the owner's req drops while in ADDR, abandon: go to IDLE with no pulse and `last` unchanged.
- WAIT: `mem_req`=0. On `mem_data_ok`, latch `mem_rdata` (reads; 0 for writes) and go to RESP. A `mem_data_ok` seen in any other state is ignored.
- RESP: pulse the owner's `dok` when its req is still high and its current addr equals the latched addr. Otherwise suppress the pulse (stale refill must not write the cache). Update `last`:=owner and return to IDLE.
- `*_rdata` holds the last latched value between pulses. The non-owner's `dok` is always 0.
- The req that drops in the cycle after `dok` (cache now hits) is never re-granted, because RESP always passes through IDLE.
- Reset, asynchronous, mid-transaction: state goes to IDLE and the outstanding memory transaction is forgotten. The memory side is reset by the same `resetn`.

## Timing
- Reset values: `mem_req`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, both `dok`=0, both `rdata`=0, `last` such that `RR_INIT` wins first.
- All outputs decode from registered state only; no combinational path from any input to any output.
- Minimum latency, with `mem_addr_ok` and `mem_data_ok` at first opportunity:
  - req high at cycle 0
  - `mem_req` at cycle 1
  - WAIT at cycle 2 with `mem_data_ok` at cycle 2
  - `dok` at cycle 3
  - next grant evaluated at cycle 4.
- `mem_addr_ok` and `mem_data_ok` arriving in the same cycle while in ADDR: accept the address only. The response is expected later.

## Test plan
- Inst read alone: addr 0xBFC00000, memory gives `addr_ok` at cycle 1 and `data_ok` with 0x3C1DA000 at cycle 2. Required: `inst_cache_dok`=1 at cycle 3 with rdata 0x3C1DA000, `data_cache_dok` stays 0.
- Simultaneous requests after reset (`RR_INIT`=0): inst read 0x100 and data write 0x2000 with wdata 0xDEADBEEF, wstrb 0xF. Required: first `mem_req` carries wr=1, addr 0x2000, wstrb 0xF. Second carries wr=0, addr 0x100. Dok pulses in that order.
- Back-to-back data requests while inst is held high: order must alternate data, inst, data. Neither side is granted twice in a row.
- Withdraw: inst req drops in ADDR before `mem_addr_ok`. Required: state returns to IDLE, no `dok`, `mem_req` falls next cycle.
- Stale refill: inst addr changes 0x100→0x200 during WAIT. Required: no `inst_cache_dok` for 0x100. The 0x200 request is issued next, yielding `dok` with its own data.
- Reset asserted during WAIT: all outputs reach their reset values immediately. A late `mem_data_ok` after release produces no `dok`.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one SRAM-like memory port between the instruction
// refill path and the data path; one outstanding transaction, registered outputs.
module cache_mem_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_cache_req,
  input  logic [31:0] inst_cache_addr,
  output logic [31:0] inst_cache_rdata,
  output logic        inst_cache_dok,
  input  logic        data_cache_req,
  input  logic        data_cache_wr,
  input  logic [31:0] data_cache_addr,
  input  logic [31:0] data_cache_wdata,
  input  logic [3:0]  data_cache_wstrb,
  output logic [31:0] data_cache_rdata,
  output logic        data_cache_dok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  state_dbg
);

  // Handshakes: a cache req is held until its dok pulse (or withdrawn); mem_req is
  // held with a stable payload until mem_addr_ok, and mem_data_ok is only honoured
  // in WAIT, one cycle or more after the address was accepted.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;

  logic        last_q;   // side served last: 1 = instruction, 0 = data
  logic        owner_q;  // side currently granted: 1 = instruction, 0 = data
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] inst_rdata_q;
  logic [31:0] data_rdata_q;
  logic        inst_dok_q;
  logic        data_dok_q;

  logic        any_req;
  logic        grant_inst;
  logic        owner_req;
  logic [31:0] owner_addr;
  logic        resp_ok;
  logic [31:0] resp_data;

  always_comb begin
    any_req    = inst_cache_req | data_cache_req;
    grant_inst = inst_cache_req & (~data_cache_req | ~last_q);
    owner_req  = owner_q ? inst_cache_req  : data_cache_req;
    owner_addr = owner_q ? inst_cache_addr : data_cache_addr;
    // A response only completes if the owner still wants the same address.
    resp_ok    = owner_req & (owner_addr == addr_q);
    resp_data  = wr_q ? 32'h0 : mem_rdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (any_req) state_d = ADDR;
      // An accepted address must be completed, so acceptance wins over withdrawal.
      ADDR: begin
        if (mem_addr_ok)     state_d = WAIT;
        else if (!owner_req) state_d = IDLE;
      end
      WAIT: if (mem_data_ok) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req          = (state_q == ADDR);
    mem_wr           = wr_q;
    mem_addr         = addr_q;
    mem_wdata        = wdata_q;
    mem_wstrb        = wstrb_q;
    inst_cache_dok   = inst_dok_q;
    data_cache_dok   = data_dok_q;
    inst_cache_rdata = inst_rdata_q;
    data_cache_rdata = data_rdata_q;
    state_dbg        = state_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q       <= ~RR_INIT;
      owner_q      <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'h0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
      inst_dok_q   <= 1'b0;
      data_dok_q   <= 1'b0;
    end else begin
      inst_dok_q <= 1'b0;
      data_dok_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= grant_inst;
            if (grant_inst) begin
              wr_q    <= 1'b0;
              addr_q  <= inst_cache_addr;
              wdata_q <= 32'h0;
              wstrb_q <= 4'h0;
            end else begin
              wr_q    <= data_cache_wr;
              addr_q  <= data_cache_addr;
              wdata_q <= data_cache_wdata;
              wstrb_q <= data_cache_wr ? data_cache_wstrb : 4'h0;
            end
          end
        end
        WAIT: begin
          // The pulse is registered here so it appears in RESP without any input path.
          if (mem_data_ok && resp_ok) begin
            if (owner_q) begin
              inst_dok_q   <= 1'b1;
              inst_rdata_q <= resp_data;
            end else begin
              data_dok_q   <= 1'b1;
              data_rdata_q <= resp_data;
            end
          end
        end
        RESP: last_q <= owner_q;
        default: ;
      endcase
    end
  end

endmodule
